mcm_collector: RTL and testbench
================================

Name: mcm_collector

Overview:
Upstream stage of the MCM packer. On each frame request it receives one MCM frame byte-by-byte from the MCM receiver and writes it linearly into the 8-bit MCM buffer RAM. It then raises done and holds it until the packer has drained all streams. A receive timeout zero-pads the rest of the frame, so the packer always sees a complete frame.

Parameters:
FRAME_BYTES, 144, bytes per MCM frame (3 streams x 16 iterations x 3 bytes); must be 1..256
NUM_STREAMS, 3, number of packer busy periods (falling edges) per frame
TIMEOUT, 16'd5000, max clk cycles between received bytes before padding starts

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
iStart  in  1  frame request strobe from orbit timing; synchronous, rising edge is used
iRxData  in  8  byte from MCM receiver
iRxValid  in  1  one-clk strobe; iRxData valid on this cycle
iPackBusy  in  1  busy from packer; may be asynchronous
oReq  out  1  one-clk request pulse to MCM
oWrData  out  8  byte to MCM RAM
oWrAddr  out  8  write address to MCM RAM
oWren  out  1  RAM write enable
oDone  out  1  frame complete in RAM; packer may read
oTimeout  out  1  sticky: current frame was zero-padded; cleared on next accepted start
oSkip  out  1  one-clk pulse: iStart rising edge dropped because the previous frame was not yet drained

Behaviour:
- Reset (async, low): all outputs 0, state IDLE, counters 0, all sync registers 0.
- iStart edge detect: a 1-bit register gives startRise = iStart & !iStartD.
- iPackBusy: 3-flop synchroniser. Fall event = sync[2] & !sync[1].
- IDLE
  - oDone = 0.
  - On startRise: oReq = 1 for one clk, byteCnt = 0, toCnt = 0, oTimeout = 0, go to RECV.
  - iRxValid is ignored.
- RECV
  - On iRxValid: oWrData = iRxData, oWrAddr = byteCnt, oWren = 1 for exactly one clk; byteCnt += 1; toCnt = 0.
  - Without iRxValid: toCnt += 1.
  - If iRxValid and toCnt == TIMEOUT-1 on the same clk, the byte wins and no timeout occurs.
  - When byteCnt reaches FRAME_BYTES after a write: go to FINISH.
  - When toCnt reaches TIMEOUT-1 without a byte: oTimeout = 1, go to PAD.
  - startRise in RECV: ignored, with oSkip pulse.
- PAD
  - One write per clk: oWrData = 0x00, oWrAddr = byteCnt, oWren = 1, byteCnt += 1, until byteCnt == FRAME_BYTES. Then go to FINISH.
  - iRxValid in PAD is ignored.
- FINISH: one clk with oWren = 0 (last write settles), then oDone = 1, fallCnt = 0, go to DRAIN.
- DRAIN
  - oDone held at 1.
  - Each packer fall event: fallCnt += 1.
  - When fallCnt reaches NUM_STREAMS: oDone = 0, go to IDLE on the same clk.
  - startRise in DRAIN: oSkip pulse, no oReq, state unchanged.
- Latency
  - iRxValid sampled at edge n: oWren high from n+1 for one clk.
  - Last byte: oDone rises at edge n+2.
  - Last packer fall observed at edge m: oDone falls at edge m.
- Widths: byteCnt 9-bit, so FRAME_BYTES = 256 terminates correctly. oWrAddr = byteCnt[7:0]. toCnt 16-bit, saturating. fallCnt 2-bit minimum (sized by NUM_STREAMS).
- oWren is never high in IDLE or DRAIN. RAM addresses are written strictly ascending, each exactly once per frame.
- Reset mid-operation: frame is abandoned, outputs forced to 0, RAM content undefined. The next frame starts from IDLE.

Test Plan:
- Normal frame: iStart pulse, then 144 bytes 0x00..0x8F, one every 10 clk → oReq single pulse; 144 oWren pulses with oWrAddr == oWrData; oDone rises 2 clk after the last byte sample; oTimeout = 0.
- Timeout, TIMEOUT=50: send 100 bytes then stop → 50 idle clk later oTimeout = 1; 44 consecutive oWren with oWrData = 0x00, addr 100..143; oDone = 1.
- Drain: with oDone = 1, drive iPackBusy as three 20-clk high pulses → oDone stays 1 after the 1st and 2nd falls; drops exactly 3 clk after the 3rd falling edge of iPackBusy (sync latency); state IDLE.
- Skip: iStart pulse during DRAIN and during RECV → oSkip 1-clk pulse each time; no oReq; byte count and oDone unaffected.
- Stray bytes: iRxValid pulses in IDLE, PAD and DRAIN → no oWren, no address change.
- Collision: iRxValid on the exact clk toCnt == TIMEOUT-1 → byte written, oTimeout stays 0. Reset low for 1 clk mid-RECV (byte 60) → all outputs 0 immediately; a new iStart produces a fresh frame from addr 0.

Source files
------------

// File: rtl/mcm_collector.sv
// Purpose: collects one MCM frame per request into the MCM buffer RAM, zero-pads on receive timeout, holds done until the packer drains.
// Latency: byte sampled at edge n is written at edge n+1; done rises at edge n+2 after the last byte; done falls on the edge the last packer fall is seen.
// Backpressure: none; the receiver is never stalled, bytes outside RECV are dropped, early frame requests are dropped and flagged on oSkip.
//
// Ports:
//   clk, reset       system clock, asynchronous active-low reset
//   iStart           frame request strobe (rising edge used, synchronous to clk)
//   iRxData/iRxValid byte stream from the MCM receiver, one-clk valid strobe
//   iPackBusy        packer busy, possibly asynchronous; each falling edge ends one stream
//   oReq             one-clk request pulse to the MCM
//   oWrData/oWrAddr/oWren  write port of the 8-bit MCM buffer RAM
//   oDone            frame complete in RAM, packer may read
//   oTimeout         sticky: current frame was zero-padded
//   oSkip            one-clk pulse: a frame request was dropped
module mcm_collector #(
    parameter int          FRAME_BYTES = 144,
    parameter int          NUM_STREAMS = 3,
    parameter logic [15:0] TIMEOUT     = 16'd5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iStart,
    input  logic [7:0] iRxData,
    input  logic       iRxValid,
    input  logic       iPackBusy,
    output logic       oReq,
    output logic [7:0] oWrData,
    output logic [7:0] oWrAddr,
    output logic       oWren,
    output logic       oDone,
    output logic       oTimeout,
    output logic       oSkip
);

    localparam int                FALL_W    = ($clog2(NUM_STREAMS + 1) < 2) ? 2 : $clog2(NUM_STREAMS + 1);
    localparam logic [8:0]        LAST_IDX  = 9'(FRAME_BYTES - 1);
    localparam logic [FALL_W-1:0] LAST_FALL = FALL_W'(NUM_STREAMS - 1);
    localparam logic [15:0]       TO_LAST   = TIMEOUT - 16'd1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RECV   = 3'd1,
        PAD    = 3'd2,
        FINISH = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    state_t             state;
    state_t             stateNxt;

    logic               iStartD;
    logic [2:0]         busySync;
    logic               rxValidQ;
    logic [7:0]         rxDataQ;

    logic [8:0]         byteCnt;
    logic [8:0]         byteCntNxt;
    logic [15:0]        toCnt;
    logic [15:0]        toCntNxt;
    logic [FALL_W-1:0]  fallCnt;
    logic [FALL_W-1:0]  fallCntNxt;

    logic               reqNxt;
    logic [7:0]         wrDataNxt;
    logic [7:0]         wrAddrNxt;
    logic               wrenNxt;
    logic               doneNxt;
    logic               timeoutNxt;
    logic               skipNxt;

    logic               startRise;
    logic               packFall;
    logic               lastByte;
    logic               toExpired;

    assign startRise = iStart & ~iStartD;
    // Fall is taken between the last two synchroniser stages so that only
    // settled values are compared.
    assign packFall  = busySync[2] & ~busySync[1];
    assign lastByte  = (byteCnt == LAST_IDX);
    assign toExpired = (toCnt == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            iStartD  <= 1'b0;
            busySync <= 3'b000;
            rxValidQ <= 1'b0;
            rxDataQ  <= 8'h00;
            byteCnt  <= 9'd0;
            toCnt    <= 16'd0;
            fallCnt  <= '0;
            oReq     <= 1'b0;
            oWrData  <= 8'h00;
            oWrAddr  <= 8'h00;
            oWren    <= 1'b0;
            oDone    <= 1'b0;
            oTimeout <= 1'b0;
            oSkip    <= 1'b0;
        end else begin
            state    <= stateNxt;
            iStartD  <= iStart;
            busySync <= {busySync[1:0], iPackBusy};
            // Bytes are only captured while a frame is being received, so a
            // byte that coincides with the start request or arrives in any
            // other state never reaches the RAM.
            rxValidQ <= iRxValid & (state == RECV);
            rxDataQ  <= iRxData;
            byteCnt  <= byteCntNxt;
            toCnt    <= toCntNxt;
            fallCnt  <= fallCntNxt;
            oReq     <= reqNxt;
            oWrData  <= wrDataNxt;
            oWrAddr  <= wrAddrNxt;
            oWren    <= wrenNxt;
            oDone    <= doneNxt;
            oTimeout <= timeoutNxt;
            oSkip    <= skipNxt;
        end
    end

    always_comb begin
        stateNxt   = state;
        byteCntNxt = byteCnt;
        toCntNxt   = toCnt;
        fallCntNxt = fallCnt;
        reqNxt     = 1'b0;
        wrDataNxt  = oWrData;
        wrAddrNxt  = oWrAddr;
        wrenNxt    = 1'b0;
        doneNxt    = oDone;
        timeoutNxt = oTimeout;
        // Any request arriving while a frame is still in flight is dropped.
        skipNxt    = startRise && (state != IDLE);

        case (state)
            IDLE: begin
                doneNxt = 1'b0;
                if (startRise) begin
                    reqNxt     = 1'b1;
                    byteCntNxt = 9'd0;
                    toCntNxt   = 16'd0;
                    timeoutNxt = 1'b0;
                    stateNxt   = RECV;
                end
            end

            RECV: begin
                // A byte arriving on the expiry clk wins over the timeout.
                if (rxValidQ) begin
                    wrDataNxt  = rxDataQ;
                    wrAddrNxt  = byteCnt[7:0];
                    wrenNxt    = 1'b1;
                    byteCntNxt = byteCnt + 9'd1;
                    toCntNxt   = 16'd0;
                    if (lastByte) begin
                        stateNxt = FINISH;
                    end
                end else if (toExpired) begin
                    timeoutNxt = 1'b1;
                    stateNxt   = PAD;
                end else if (toCnt != 16'hFFFF) begin
                    toCntNxt = toCnt + 16'd1;
                end
            end

            PAD: begin
                wrDataNxt  = 8'h00;
                wrAddrNxt  = byteCnt[7:0];
                wrenNxt    = 1'b1;
                byteCntNxt = byteCnt + 9'd1;
                if (lastByte) begin
                    stateNxt = FINISH;
                end
            end

            FINISH: begin
                // One quiet clk lets the final RAM write settle before the
                // packer is allowed to read.
                doneNxt    = 1'b1;
                fallCntNxt = '0;
                stateNxt   = DRAIN;
            end

            DRAIN: begin
                if (packFall) begin
                    fallCntNxt = fallCnt + FALL_W'(1);
                    if (fallCnt == LAST_FALL) begin
                        doneNxt  = 1'b0;
                        stateNxt = IDLE;
                    end
                end
            end

            default: begin
                stateNxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mcm_collector.sv
// Bench for mcm_collector: randomized byte streams and gaps, checked against an
// expected RAM-write schedule (address, data, edge) built from the frame rules,
// plus request/skip/done/timeout event timing recorded by a passive monitor.
module tb_mcm_collector;

    localparam int FB = 144;
    localparam int NS = 3;
    localparam int TO = 50;

    logic       clk;
    logic       reset;
    logic       iStart;
    logic [7:0] iRxData;
    logic       iRxValid;
    logic       iPackBusy;
    logic       oReq;
    logic [7:0] oWrData;
    logic [7:0] oWrAddr;
    logic       oWren;
    logic       oDone;
    logic       oTimeout;
    logic       oSkip;

    mcm_collector #(
        .FRAME_BYTES(FB),
        .NUM_STREAMS(NS),
        .TIMEOUT    (16'(TO))
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .iStart   (iStart),
        .iRxData  (iRxData),
        .iRxValid (iRxValid),
        .iPackBusy(iPackBusy),
        .oReq     (oReq),
        .oWrData  (oWrData),
        .oWrAddr  (oWrAddr),
        .oWren    (oWren),
        .oDone    (oDone),
        .oTimeout (oTimeout),
        .oSkip    (oSkip)
    );

    int total = 0;
    int bad   = 0;

    // ec = number of rising clock edges seen so far (updated 1 time unit after each edge)
    int ec = 0;
    int wrAddrQ[$];
    int wrDataQ[$];
    int wrEdgeQ[$];
    int reqEdgeQ[$];
    int skipEdgeQ[$];
    int doneRiseEdge = -1;
    int doneFallEdge = -1;
    int toRiseEdge   = -1;
    logic doneP = 1'b0;
    logic toP   = 1'b0;

    // expected write schedule for the current frame
    int expAddr[$];
    int expData[$];
    int expEdge[$];
    int wrBase;
    int reqBase;
    int skipBase;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit at edge %0d", ec);
        $fatal(1, "watchdog");
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ec = ec + 1;
            if (oWren === 1'b1) begin
                wrAddrQ.push_back(int'(oWrAddr));
                wrDataQ.push_back(int'(oWrData));
                wrEdgeQ.push_back(ec);
            end
            if (oReq === 1'b1) reqEdgeQ.push_back(ec);
            if (oSkip === 1'b1) skipEdgeQ.push_back(ec);
            if (oDone === 1'b1 && doneP === 1'b0) doneRiseEdge = ec;
            if (oDone === 1'b0 && doneP === 1'b1) doneFallEdge = ec;
            if (oTimeout === 1'b1 && toP === 1'b0) toRiseEdge = ec;
            doneP = oDone;
            toP   = oTimeout;
        end
    end

    // ---------------- stimulus / model helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic startFrame(output int se);
        iStart = 1'b1;
        se = ec + 1;
        tick();
        iStart = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] d, output int se);
        iRxData  = d;
        iRxValid = 1'b1;
        se = ec + 1;
        tick();
        iRxValid = 1'b0;
    endtask

    task automatic newFrame();
        wrBase   = wrAddrQ.size();
        reqBase  = reqEdgeQ.size();
        skipBase = skipEdgeQ.size();
        expAddr.delete();
        expData.delete();
        expEdge.delete();
    endtask

    // a byte sampled at edge s lands in RAM on edge s+1
    task automatic modelWrite(input int a, input int d, input int ed);
        expAddr.push_back(a);
        expData.push_back(d);
        expEdge.push_back(ed);
    endtask

    task automatic packerDrain();
        for (int p = 0; p < NS; p++) begin
            iPackBusy = 1'b1;
            repeat (20) tick();
            iPackBusy = 1'b0;
            repeat (20) tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        total++;
        if ({oReq, oWrData, oWrAddr, oWren, oDone, oTimeout, oSkip} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0", {oReq, oWrData, oWrAddr, oWren, oDone, oTimeout, oSkip});
        end
        reset = 1'b1;
        repeat (3) tick();
        total++;
        if ({oReq, oWren, oDone, oTimeout, oSkip} !== 5'd0) begin
            bad++;
            $display("FAIL reset_idle_quiet got=%b want=0", {oReq, oWren, oDone, oTimeout, oSkip});
        end
    endtask

    task automatic test_normal_frame();
        int sReq;
        int s;
        newFrame();
        startFrame(sReq);
        for (int i = 0; i < FB; i++) begin
            repeat (9) tick();
            sendByte(8'(i), s);
            modelWrite(i, i, s + 1);
        end
        repeat (5) tick();
        total++;
        if (reqEdgeQ.size() - reqBase !== 1 || reqEdgeQ[reqBase] !== sReq) begin
            bad++;
            $display("FAIL normal_req got count=%0d want count=1 at edge %0d", reqEdgeQ.size() - reqBase, sReq);
        end
        total++;
        if (wrAddrQ.size() - wrBase !== expAddr.size()) begin
            bad++;
            $display("FAIL normal_wr_count got=%0d want=%0d", wrAddrQ.size() - wrBase, expAddr.size());
        end
        for (int i = 0; i < expAddr.size() && wrBase + i < wrAddrQ.size(); i++) begin
            total++;
            if ({wrAddrQ[wrBase+i], wrDataQ[wrBase+i], wrEdgeQ[wrBase+i]} !== {expAddr[i], expData[i], expEdge[i]}) begin
                bad++;
                $display("FAIL normal_wr%0d got a=%0d d=%0d e=%0d want a=%0d d=%0d e=%0d", i,
                         wrAddrQ[wrBase+i], wrDataQ[wrBase+i], wrEdgeQ[wrBase+i], expAddr[i], expData[i], expEdge[i]);
            end
        end
        total++;
        if (doneRiseEdge !== s + 2) begin
            bad++;
            $display("FAIL normal_done_edge got=%0d want=%0d", doneRiseEdge, s + 2);
        end
        total++;
        if (oDone !== 1'b1 || oTimeout !== 1'b0) begin
            bad++;
            $display("FAIL normal_flags got done=%b timeout=%b want done=1 timeout=0", oDone, oTimeout);
        end
    endtask

    task automatic test_drain();
        int e;
        int s;
        for (int p = 0; p < NS; p++) begin
            iPackBusy = 1'b1;
            repeat (20) tick();
            iPackBusy = 1'b0;
            e = ec + 1;
            repeat (20) tick();
            if (p < NS - 1) begin
                total++;
                if (oDone !== 1'b1) begin
                    bad++;
                    $display("FAIL drain_hold%0d got done=%b want 1", p, oDone);
                end
            end else begin
                total++;
                if (doneFallEdge !== e + 2 || oDone !== 1'b0) begin
                    bad++;
                    $display("FAIL drain_fall got edge=%0d done=%b want edge=%0d done=0", doneFallEdge, oDone, e + 2);
                end
            end
        end
        // stray byte in IDLE
        wrBase = wrAddrQ.size();
        sendByte(8'hAA, s);
        repeat (5) tick();
        total++;
        if (wrAddrQ.size() !== wrBase) begin
            bad++;
            $display("FAIL stray_idle got writes=%0d want 0", wrAddrQ.size() - wrBase);
        end
    endtask

    task automatic test_skip();
        int sReq;
        int s;
        int sLast;
        int sk1;
        int sk2;
        newFrame();
        startFrame(sReq);
        sk1 = -1;
        for (int i = 0; i < FB; i++) begin
            if (i == 70) begin
                iStart = 1'b1;
                sk1 = ec + 1;
                tick();
                iStart = 1'b0;
            end
            repeat ($urandom_range(0, 4)) tick();
            iRxData = 8'($urandom);
            sendByte(iRxData, s);
            modelWrite(i, int'(iRxData), s + 1);
        end
        sLast = s;
        repeat (5) tick();
        // stray byte and a new request while draining
        sendByte(8'h5A, s);
        repeat (2) tick();
        iStart = 1'b1;
        sk2 = ec + 1;
        tick();
        iStart = 1'b0;
        repeat (4) tick();

        total++;
        if (reqEdgeQ.size() - reqBase !== 1 || reqEdgeQ[reqBase] !== sReq) begin
            bad++;
            $display("FAIL skip_req got count=%0d want count=1 at edge %0d", reqEdgeQ.size() - reqBase, sReq);
        end
        total++;
        if (skipEdgeQ.size() - skipBase !== 2) begin
            bad++;
            $display("FAIL skip_count got=%0d want=2", skipEdgeQ.size() - skipBase);
        end else begin
            total++;
            if (skipEdgeQ[skipBase] !== sk1 || skipEdgeQ[skipBase+1] !== sk2) begin
                bad++;
                $display("FAIL skip_edges got %0d,%0d want %0d,%0d", skipEdgeQ[skipBase], skipEdgeQ[skipBase+1], sk1, sk2);
            end
        end
        total++;
        if (wrAddrQ.size() - wrBase !== expAddr.size()) begin
            bad++;
            $display("FAIL skip_wr_count got=%0d want=%0d", wrAddrQ.size() - wrBase, expAddr.size());
        end
        for (int i = 0; i < expAddr.size() && wrBase + i < wrAddrQ.size(); i++) begin
            total++;
            if ({wrAddrQ[wrBase+i], wrDataQ[wrBase+i], wrEdgeQ[wrBase+i]} !== {expAddr[i], expData[i], expEdge[i]}) begin
                bad++;
                $display("FAIL skip_wr%0d got a=%0d d=%0d e=%0d want a=%0d d=%0d e=%0d", i,
                         wrAddrQ[wrBase+i], wrDataQ[wrBase+i], wrEdgeQ[wrBase+i], expAddr[i], expData[i], expEdge[i]);
            end
        end
        total++;
        if (doneRiseEdge !== sLast + 2 || oDone !== 1'b1) begin
            bad++;
            $display("FAIL skip_done got edge=%0d done=%b want edge=%0d done=1", doneRiseEdge, oDone, sLast + 2);
        end
        packerDrain();
        total++;
        if (oDone !== 1'b0) begin
            bad++;
            $display("FAIL skip_drained got done=%b want 0", oDone);
        end
    endtask

    task automatic test_timeout();
        int sReq;
        int s;
        int t;
        int sStray;
        newFrame();
        startFrame(sReq);
        for (int i = 0; i < 100; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            iRxData = 8'($urandom);
            sendByte(iRxData, s);
            modelWrite(i, int'(iRxData), s + 1);
        end
        // last write at s+1; TO clk of silence later the frame is padded
        t = s + 1 + TO;
        for (int j = 100; j < FB; j++) modelWrite(j, 0, t + 1 + (j - 100));
        while (ec + 1 < t + 5) tick();
        sendByte(8'hFF, sStray);
        repeat (70) tick();

        total++;
        if (toRiseEdge !== t || oTimeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_flag got edge=%0d flag=%b want edge=%0d flag=1", toRiseEdge, oTimeout, t);
        end
        total++;
        if (wrAddrQ.size() - wrBase !== expAddr.size()) begin
            bad++;
            $display("FAIL timeout_wr_count got=%0d want=%0d", wrAddrQ.size() - wrBase, expAddr.size());
        end
        for (int i = 0; i < expAddr.size() && wrBase + i < wrAddrQ.size(); i++) begin
            total++;
            if ({wrAddrQ[wrBase+i], wrDataQ[wrBase+i], wrEdgeQ[wrBase+i]} !== {expAddr[i], expData[i], expEdge[i]}) begin
                bad++;
                $display("FAIL timeout_wr%0d got a=%0d d=%0d e=%0d want a=%0d d=%0d e=%0d", i,
                         wrAddrQ[wrBase+i], wrDataQ[wrBase+i], wrEdgeQ[wrBase+i], expAddr[i], expData[i], expEdge[i]);
            end
        end
        total++;
        if (doneRiseEdge !== t + 45 || oDone !== 1'b1) begin
            bad++;
            $display("FAIL timeout_done got edge=%0d done=%b want edge=%0d done=1", doneRiseEdge, oDone, t + 45);
        end
        packerDrain();
        total++;
        if (oDone !== 1'b0 || oTimeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky got done=%b timeout=%b want done=0 timeout=1", oDone, oTimeout);
        end
    endtask

    task automatic test_collision_reset();
        int sReq;
        int s;
        int sLast;
        newFrame();
        startFrame(sReq);
        repeat (2) tick();
        total++;
        if (oTimeout !== 1'b0) begin
            bad++;
            $display("FAIL coll_timeout_clear got=%b want 0", oTimeout);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            iRxData = 8'($urandom);
            sendByte(iRxData, s);
            modelWrite(i, int'(iRxData), s + 1);
        end
        // this byte reaches the FSM on the very clk the silence counter expires
        while (ec + 1 < s + TO) tick();
        iRxData = 8'($urandom);
        sendByte(iRxData, s);
        modelWrite(5, int'(iRxData), s + 1);
        for (int i = 6; i < 60; i++) begin
            iRxData = 8'($urandom);
            sendByte(iRxData, s);
            modelWrite(i, int'(iRxData), s + 1);
        end
        repeat (3) tick();
        total++;
        if (oTimeout !== 1'b0) begin
            bad++;
            $display("FAIL coll_no_timeout got=%b want 0", oTimeout);
        end
        total++;
        if (wrAddrQ.size() - wrBase !== expAddr.size()) begin
            bad++;
            $display("FAIL coll_wr_count got=%0d want=%0d", wrAddrQ.size() - wrBase, expAddr.size());
        end
        for (int i = 0; i < expAddr.size() && wrBase + i < wrAddrQ.size(); i++) begin
            total++;
            if ({wrAddrQ[wrBase+i], wrDataQ[wrBase+i], wrEdgeQ[wrBase+i]} !== {expAddr[i], expData[i], expEdge[i]}) begin
                bad++;
                $display("FAIL coll_wr%0d got a=%0d d=%0d e=%0d want a=%0d d=%0d e=%0d", i,
                         wrAddrQ[wrBase+i], wrDataQ[wrBase+i], wrEdgeQ[wrBase+i], expAddr[i], expData[i], expEdge[i]);
            end
        end

        // abandon the frame with a one-clk reset pulse
        reset = 1'b0;
        #1;
        total++;
        if ({oReq, oWrData, oWrAddr, oWren, oDone, oTimeout, oSkip} !== 21'd0) begin
            bad++;
            $display("FAIL midreset_outputs got=%b want=0", {oReq, oWrData, oWrAddr, oWren, oDone, oTimeout, oSkip});
        end
        tick();
        reset = 1'b1;
        repeat (3) tick();

        // fresh frame after reset
        newFrame();
        startFrame(sReq);
        for (int i = 0; i < FB; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            iRxData = 8'($urandom);
            sendByte(iRxData, s);
            modelWrite(i, int'(iRxData), s + 1);
        end
        sLast = s;
        repeat (5) tick();
        total++;
        if (reqEdgeQ.size() - reqBase !== 1 || reqEdgeQ[reqBase] !== sReq) begin
            bad++;
            $display("FAIL fresh_req got count=%0d want count=1 at edge %0d", reqEdgeQ.size() - reqBase, sReq);
        end
        total++;
        if (wrAddrQ.size() - wrBase !== expAddr.size()) begin
            bad++;
            $display("FAIL fresh_wr_count got=%0d want=%0d", wrAddrQ.size() - wrBase, expAddr.size());
        end
        for (int i = 0; i < expAddr.size() && wrBase + i < wrAddrQ.size(); i++) begin
            total++;
            if ({wrAddrQ[wrBase+i], wrDataQ[wrBase+i], wrEdgeQ[wrBase+i]} !== {expAddr[i], expData[i], expEdge[i]}) begin
                bad++;
                $display("FAIL fresh_wr%0d got a=%0d d=%0d e=%0d want a=%0d d=%0d e=%0d", i,
                         wrAddrQ[wrBase+i], wrDataQ[wrBase+i], wrEdgeQ[wrBase+i], expAddr[i], expData[i], expEdge[i]);
            end
        end
        total++;
        if (doneRiseEdge !== sLast + 2 || oTimeout !== 1'b0) begin
            bad++;
            $display("FAIL fresh_done got edge=%0d timeout=%b want edge=%0d timeout=0", doneRiseEdge, oTimeout, sLast + 2);
        end
        packerDrain();
        total++;
        if (oDone !== 1'b0) begin
            bad++;
            $display("FAIL fresh_drained got done=%b want 0", oDone);
        end
    endtask

    initial begin
        reset     = 1'b0;
        iStart    = 1'b0;
        iRxData   = 8'h00;
        iRxValid  = 1'b0;
        iPackBusy = 1'b0;
        tick();
        test_reset();
        test_normal_frame();
        test_drain();
        test_skip();
        test_timeout();
        test_collision_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
